fir_ntap_pipe: RTL and testbench

Parametrised, pipelined direct-form FIR filter with signed arithmetic, runtime-loadable coefficients and a valid-qualified sample stream. It succeeds the fixed 16-tap unpipelined filter in the DSP datapath and is the default filter instance for new sample-stream chains. Coefficients reset to the legacy ramp 1..TAPS, so an unconfigured instance reproduces the legacy impulse response.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_adder_tree.sv | 39 +++
 rtl/fir_ntap_pipe.sv | 86 ++++++++
 tb/tb_fir_ntap_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared helpers for the pipelined FIR family: width derivation and the
// reset coefficient ramp.
package fir_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int fir_aw(input int taps);
    return clog2(taps);
  endfunction

  function automatic int fir_ow(input int dw, input int cw, input int taps);
    return dw + cw + clog2(taps);
  endfunction

  // Legacy ramp 1..TAPS so an unconfigured filter matches the old impulse response.
  function automatic int fir_default_coef(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Registered pairwise signed adder tree; leaves beyond N are padded with zero
// so any N >= 2 maps onto a full binary tree of clog2(N) levels.
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int N  = 16,
  parameter int IW = 32,
  parameter int OW = 36
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0][IW-1:0] leaf_i,
  output logic signed [OW-1:0] sum_o
);

  localparam int L = clog2(N);
  localparam int P = 1 << L;

  logic signed [OW-1:0] leaf_ext [P];
  logic signed [OW-1:0] node_q [P-1:1];

  always_comb begin
    for (int k = 0; k < P; k++) leaf_ext[k] = '0;
    for (int k = 0; k < N; k++) leaf_ext[k] = {{(OW-IW){leaf_i[k][IW-1]}}, leaf_i[k]};
  end

  // Heap layout: node n sums children 2n and 2n+1, node 1 is the root.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 1; n < P; n++) node_q[n] <= '0;
    end else begin
      for (int n = P/2; n < P; n++) node_q[n] <= leaf_ext[2*n-P] + leaf_ext[2*n-P+1];
      for (int n = 1; n < P/2; n++) node_q[n] <= node_q[2*n] + node_q[2*n+1];
    end
  end

  assign sum_o = node_q[1];

endmodule

// File: rtl/fir_ntap_pipe.sv
// Pipelined direct-form FIR: delay line, runtime coefficient file, registered
// products and a registered adder tree, with a matching valid pipeline.
module fir_ntap_pipe
  import fir_pkg::*;
#(
  parameter int TAPS = 16,
  parameter int DW   = 16,
  parameter int CW   = 16,
  localparam int AW  = fir_aw(TAPS),
  localparam int OW  = fir_ow(DW, CW, TAPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 out_valid,
  output logic signed [OW-1:0] out_data
);

  localparam int L  = clog2(TAPS);
  localparam int PW = DW + CW;

  logic signed [DW-1:0] tap_q  [TAPS];
  logic signed [CW-1:0] coef_q [TAPS];
  logic signed [PW-1:0] prod_q [TAPS];
  logic [TAPS-1:0][PW-1:0] leaf;
  logic [L+1:0] vld_q;

  // Clear keeps only the sample arriving with it (if any) as history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) tap_q[k] <= '0;
    end else if (clear) begin
      tap_q[0] <= in_valid ? in_data : '0;
      for (int k = 1; k < TAPS; k++) tap_q[k] <= '0;
    end else if (in_valid) begin
      tap_q[0] <= in_data;
      for (int k = 1; k < TAPS; k++) tap_q[k] <= tap_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) coef_q[k] <= CW'(fir_default_coef(k));
    end else if (coef_we) begin
      for (int k = 0; k < TAPS; k++)
        if (coef_addr == AW'(k)) coef_q[k] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) prod_q[k] <= PW'(coef_q[k]) * PW'(tap_q[k]);
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) leaf[k] = prod_q[k];
  end

  // Stage 0 tracks the accept edge; stage L+1 lines up with the tree root.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= {vld_q[L:0], in_valid};
  end

  fir_adder_tree #(
    .N  (TAPS),
    .IW (PW),
    .OW (OW)
  ) u_tree (
    .clk_i  (clk),
    .rst_ni (reset),
    .leaf_i (leaf),
    .sum_o  (out_data)
  );

  assign out_valid = vld_q[L+1];

endmodule

// File: tb/tb_fir_ntap_pipe.sv
// Self-checking bench: a 16-tap and a 5-tap instance against a queue-based
// convolution model with per-sample expected arrival cycles.
module tb_fir_ntap_pipe;

  localparam int OWA = 36;
  localparam int OWB = 35;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rstN;
  logic                  inValid  [2];
  logic signed [15:0]    inData   [2];
  logic                  coefWe   [2];
  logic [3:0]            coefAddr [2];
  logic signed [15:0]    coefData [2];
  logic                  clearIn  [2];
  logic                  outValidA, outValidB;
  logic signed [OWA-1:0] outDataA;
  logic signed [OWB-1:0] outDataB;

  fir_ntap_pipe dutA (
    .clk       (clk),
    .reset     (rstN),
    .clear     (clearIn[0]),
    .in_valid  (inValid[0]),
    .in_data   (inData[0]),
    .coef_we   (coefWe[0]),
    .coef_addr (coefAddr[0]),
    .coef_data (coefData[0]),
    .out_valid (outValidA),
    .out_data  (outDataA)
  );

  fir_ntap_pipe #(.TAPS(5)) dutB (
    .clk       (clk),
    .reset     (rstN),
    .clear     (clearIn[1]),
    .in_valid  (inValid[1]),
    .in_data   (inData[1]),
    .coef_we   (coefWe[1]),
    .coef_addr (coefAddr[1][2:0]),
    .coef_data (coefData[1]),
    .out_valid (outValidB),
    .out_data  (outDataB)
  );

  int     coefM [2][16];
  longint hist [2][$];
  int     pendCyc [2][$];
  longint pendVal [2][$];
  longint lastData [2];
  int     cyc;
  int     checks;
  int     failures;

  function automatic int tapsOf(input int d);
    return (d == 0) ? 16 : 5;
  endfunction

  function automatic int latOf(input int d);
    return (d == 0) ? 5 : 4;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    for (int d = 0; d < 2; d++) begin
      inValid[d]  = 1'b0;
      inData[d]   = '0;
      coefWe[d]   = 1'b0;
      coefAddr[d] = '0;
      coefData[d] = '0;
      clearIn[d]  = 1'b0;
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      hist[d].delete();
      pendCyc[d].delete();
      pendVal[d].delete();
      lastData[d] = 0;
      for (int k = 0; k < 16; k++) coefM[d][k] = k + 1;
    end
  endtask

  // y[n] = sum c[k]*x[n-k] over the accepted-sample history, newest first.
  task automatic modelEdge();
    if (!rstN) return;
    for (int d = 0; d < 2; d++) begin
      longint y;
      int a;
      a = int'(coefAddr[d]);
      if (coefWe[d] && a < tapsOf(d)) coefM[d][a] = int'(coefData[d]);
      if (clearIn[d]) hist[d].delete();
      if (inValid[d]) begin
        hist[d].push_front(longint'(inData[d]));
        while (hist[d].size() > tapsOf(d)) void'(hist[d].pop_back());
        y = 0;
        for (int k = 0; k < hist[d].size(); k++) y += longint'(coefM[d][k]) * hist[d][k];
        pendCyc[d].push_back(cyc + latOf(d));
        pendVal[d].push_back(y);
      end
    end
  endtask

  task automatic checkAll();
    for (int d = 0; d < 2; d++) begin
      bit expV;
      logic signed [63:0] obsV, obsD;
      string nm;
      nm = (d == 0) ? "A" : "B";
      expV = (pendCyc[d].size() > 0) && (pendCyc[d][0] == cyc);
      if (expV) begin
        lastData[d] = pendVal[d][0];
        void'(pendCyc[d].pop_front());
        void'(pendVal[d].pop_front());
      end
      obsV = (d == 0) ? {63'd0, outValidA} : {63'd0, outValidB};
      obsD = (d == 0) ? 64'(outDataA) : 64'(outDataB);
      checkOutput($sformatf("%s.valid@%0d", nm, cyc), obsV, {63'd0, expV});
      if (expV || !rstN) checkOutput($sformatf("%s.data@%0d", nm, cyc), obsD, lastData[d]);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    cyc++;
    modelEdge();
    #1;
    checkAll();
    idleInputs();
  endtask

  task automatic applyStimulus(input int d, input bit v, input int x, input bit we,
                               input int addr, input int cd, input bit clr);
    inValid[d]  = v;
    inData[d]   = 16'(x);
    coefWe[d]   = we;
    coefAddr[d] = 4'(addr);
    coefData[d] = 16'(cd);
    clearIn[d]  = clr;
    stepCycle();
  endtask

  task automatic dropReset();
    rstN = 1'b0;
    #1;
    checkOutput("A.rstValid", {63'd0, outValidA}, 64'sd0);
    checkOutput("A.rstData", 64'(outDataA), 64'sd0);
    checkOutput("B.rstValid", {63'd0, outValidB}, 64'sd0);
    checkOutput("B.rstData", 64'(outDataB), 64'sd0);
    modelReset();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    idleInputs();
    dropReset();
    repeat (3) stepCycle();
    rstN = 1'b1;

    // Default coefficients: impulse gives the legacy 1..16 ramp.
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    repeat (20) applyStimulus(0, 1, 0, 0, 0, 0, 0);
    repeat (8) stepCycle();

    // Gapped stream: gaps must reappear on out_valid.
    for (int i = 0; i < 34; i++) applyStimulus(0, (i % 2) == 0, (i == 0) ? 1 : 0, 0, 0, 0, 0);
    repeat (8) stepCycle();

    // Full-scale negative times negative must not wrap.
    for (int k = 0; k < 16; k++) applyStimulus(0, 0, 0, 1, k, -32768, 0);
    repeat (20) applyStimulus(0, 1, -32768, 0, 0, 0, 0);
    repeat (8) stepCycle();

    dropReset();
    repeat (2) stepCycle();
    rstN = 1'b1;

    // Coefficient write on the accept edge applies to that sample only onward.
    applyStimulus(0, 1, 7, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 100, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0);
    repeat (8) stepCycle();
    applyStimulus(0, 0, 0, 1, 0, 1, 0);

    // Clear after a DC run, with and without a sample on the same edge.
    repeat (20) applyStimulus(0, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 0, 0, 1);
    repeat (3) applyStimulus(0, 1, 2, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    repeat (3) applyStimulus(0, 1, 3, 0, 0, 0, 0);
    repeat (8) stepCycle();

    // Reset with results in flight, then coefficients must be the ramp again.
    applyStimulus(0, 0, 0, 1, 3, -9, 0);
    repeat (3) applyStimulus(0, 1, 11, 0, 0, 0, 0);
    dropReset();
    repeat (2) stepCycle();
    rstN = 1'b1;
    repeat (10) stepCycle();
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    repeat (20) applyStimulus(0, 1, 0, 0, 0, 0, 0);
    repeat (8) stepCycle();

    // Five-tap instance: padded tree, latency 4, out-of-range writes ignored.
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    repeat (8) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    repeat (6) stepCycle();
    applyStimulus(1, 0, 0, 1, 6, 999, 0);
    applyStimulus(1, 0, 0, 1, 7, -999, 0);
    applyStimulus(1, 0, 0, 1, 2, -3, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    repeat (6) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    repeat (6) stepCycle();

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        inValid[d]  = ($urandom_range(0, 3) != 0);
        inData[d]   = 16'($urandom);
        coefWe[d]   = ($urandom_range(0, 15) == 0);
        coefAddr[d] = (d == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
        coefData[d] = 16'($urandom);
        clearIn[d]  = ($urandom_range(0, 31) == 0);
      end
      stepCycle();
    end
    repeat (10) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
